// File: rtl/rr_grant_decoder.sv
// -----------------------------------------------------------------------------
// rr_grant_decoder
//
// Purpose:
//   Round-robin arbiter that shares one downstream resource among N
//   requesters. It produces a registered binary grant index and the matching
//   one-hot grant vector, which is the IDXW-to-N decode of that index. A
//   two-state FSM (IDLE/GRANT) sequences ownership. A rotating priority
//   pointer, which moves only when a grant issues, gives fairness. Every
//   change of owner passes through IDLE, so there is always a one-cycle
//   bubble between owners.
//
// Configuration macro:
//   ARB_TIMEOUT_EN - when defined, a hold counter limits one owner to
//                    MAX_HOLD consecutive GRANT cycles. After that the FSM
//                    is forced back to IDLE for a fresh arbitration. When
//                    undefined, a grant lasts for as long as the owner
//                    requests and En stays high.
//
// Ports:
//   clk           in   1     rising-edge clock
//   rst           in   1     synchronous reset, active-high
//   En            in   1     arbitration enable
//   req           in   N     per-requester request, held high while wanted
//   grant_valid   out  1     a grant is active (registered)
//   grant_idx     out  IDXW  index of the granted requester (registered)
//   grant_onehot  out  N     decode of grant_idx, all zeros when not valid
//   dbg_state_o   out  1     current FSM state (0 = IDLE, 1 = GRANT)
//   dbg_ptr_o     out  IDXW  current round-robin priority pointer
//
// Handshake:
//   A requester holds req high for as long as it wants the resource. It owns
//   the resource in every cycle in which grant_valid=1 and grant_idx equals
//   its index. Dropping req (or En) ends the grant at the next edge.
// -----------------------------------------------------------------------------
module rr_grant_decoder #(
    parameter int N        = 32,
    parameter int IDXW     = 5,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            En,
    input  logic [N-1:0]    req,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic [N-1:0]    grant_onehot,
    output logic            dbg_state_o,
    output logic [IDXW-1:0] dbg_ptr_o
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]      state_q,  state_d;
    logic [IDXW-1:0] ptr_q,    ptr_d;
    logic            valid_q,  valid_d;
    logic [IDXW-1:0] idx_q,    idx_d;
    logic [N-1:0]    onehot_q, onehot_d;

    logic            sel_found;
    logic [IDXW-1:0] sel_idx;
    logic [IDXW-1:0] cand;
    logic            hold_expired;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0] hold_q, hold_d;

    // The counter reads 0 in the first GRANT cycle. Reaching MAX_HOLD-1
    // therefore means this is the MAX_HOLD-th consecutive grant cycle.
    assign hold_expired = (state_q == GRANT) && (hold_q == HW'(MAX_HOLD - 1));

    always_comb begin
        hold_d = '0;
        if (state_q == GRANT && state_d == GRANT) begin
            hold_d = hold_q + HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    // MAX_HOLD has no effect in this build. The name keeps lint quiet about
    // the parameter not being used.
    localparam int unused_max_hold = MAX_HOLD;

    assign hold_expired = 1'b0;
`endif

    // Rotating search: scan ptr, ptr+1, ... and wrap through 0. N is a power
    // of two, so IDXW-bit addition wraps from N-1 to 0 without a modulo.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr_q + IDXW'(i);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        case (state_q)
            IDLE: begin
                if (En && sel_found) begin
                    state_d  = GRANT;
                    valid_d  = 1'b1;
                    idx_d    = sel_idx;
                    onehot_d = {{(N-1){1'b0}}, 1'b1} << sel_idx;
                    ptr_d    = sel_idx + IDXW'(1);
                end else begin
                    valid_d  = 1'b0;
                    idx_d    = '0;
                    onehot_d = '0;
                end
            end
            GRANT: begin
                // A request arriving from another requester in this cycle is
                // ignored. It is arbitrated in the IDLE cycle that follows.
                if (!En || !req[idx_q] || hold_expired) begin
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    idx_d    = '0;
                    onehot_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                valid_d  = 1'b0;
                idx_d    = '0;
                onehot_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
        end
    end

    assign grant_valid  = valid_q;
    assign grant_idx    = idx_q;
    assign grant_onehot = onehot_q;
    assign dbg_state_o  = state_q;
    assign dbg_ptr_o    = ptr_q;

endmodule

// File: tb/tb_rr_grant_decoder.sv
module tb_rr_grant_decoder;

    localparam int N    = 32;
    localparam int IDXW = 5;

    logic            clk;
    logic            rst;
    logic            En;
    logic [N-1:0]    req;
    logic            grant_valid;
    logic [IDXW-1:0] grant_idx;
    logic [N-1:0]    grant_onehot;
    logic            dbg_state_o;
    logic [IDXW-1:0] dbg_ptr_o;

    int checks;
    int errors;

    rr_grant_decoder #(
        .N        (N),
        .IDXW     (IDXW),
        .MAX_HOLD (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .En           (En),
        .req          (req),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .dbg_state_o  (dbg_state_o),
        .dbg_ptr_o    (dbg_ptr_o)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        En  = 1'b1;
        req = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({grant_valid, grant_idx, grant_onehot} !== {1'b0, 5'd0, 32'h0}) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: got v=%b idx=%0d oh=%h, expected v=0 idx=0 oh=0",
                         c, grant_valid, grant_idx, grant_onehot);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({grant_valid, grant_idx, grant_onehot} !== {1'b1, 5'd0, 32'h0000_0001}) begin
            errors++;
            $display("FAIL reset_first_grant: got v=%b idx=%0d oh=%h, expected v=1 idx=0 oh=00000001",
                     grant_valid, grant_idx, grant_onehot);
        end
        checks++;
        if (dbg_ptr_o !== 5'd1) begin
            errors++;
            $display("FAIL reset_ptr_after_grant: got %0d expected 1", dbg_ptr_o);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_sweep();
        logic [N-1:0] exp_oh;
        En = 1'b1;
        for (int i = 0; i < N; i++) begin
            exp_oh = 32'h1 << i;
            req = exp_oh;
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++;
                if ({grant_valid, grant_idx, grant_onehot} !== {1'b1, 5'(i), exp_oh}) begin
                    errors++;
                    $display("FAIL sweep_grant i=%0d cyc%0d: got v=%b idx=%0d oh=%h, expected v=1 idx=%0d oh=%h",
                             i, c, grant_valid, grant_idx, grant_onehot, i, exp_oh);
                end
            end
            req = '0;
            tick();
            checks++;
            if ({grant_valid, grant_idx, grant_onehot} !== {1'b0, 5'd0, 32'h0}) begin
                errors++;
                $display("FAIL sweep_release i=%0d: got v=%b idx=%0d oh=%h, expected all zero",
                         i, grant_valid, grant_idx, grant_onehot);
            end
            tick();
        end
    endtask

    task automatic test_rotation();
        logic [IDXW-1:0] exp_order [6];
        logic [N-1:0]    exp_oh;
        exp_order = '{5'd0, 5'd1, 5'd4, 5'd0, 5'd1, 5'd4};
        // the sweep ended with a grant to 31, so the pointer has wrapped to 0
        req = 32'h0000_0013;
        for (int k = 0; k < 6; k++) begin
            exp_oh = 32'h1 << exp_order[k];
            for (int c = 0; c < 2; c++) begin
                tick();
                checks++;
                if ({grant_valid, grant_idx, grant_onehot} !== {1'b1, exp_order[k], exp_oh}) begin
                    errors++;
                    $display("FAIL rotation_grant k=%0d cyc%0d: got v=%b idx=%0d oh=%h, expected v=1 idx=%0d oh=%h",
                             k, c, grant_valid, grant_idx, grant_onehot, exp_order[k], exp_oh);
                end
            end
            req = 32'h0000_0013 & ~exp_oh;
            tick();
            checks++;
            if ({grant_valid, grant_idx, grant_onehot} !== {1'b0, 5'd0, 32'h0}) begin
                errors++;
                $display("FAIL rotation_bubble k=%0d: got v=%b idx=%0d oh=%h, expected all zero",
                         k, grant_valid, grant_idx, grant_onehot);
            end
            req = 32'h0000_0013;
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_wrap();
        req = 32'h4000_0000;
        tick();
        checks++;
        if ({grant_valid, grant_idx, dbg_ptr_o} !== {1'b1, 5'd30, 5'd31}) begin
            errors++;
            $display("FAIL wrap_preload: got v=%b idx=%0d ptr=%0d, expected v=1 idx=30 ptr=31",
                     grant_valid, grant_idx, dbg_ptr_o);
        end
        req = '0;
        tick();
        req = 32'h8000_0001;
        tick();
        checks++;
        if ({grant_valid, grant_idx, grant_onehot} !== {1'b1, 5'd31, 32'h8000_0000}) begin
            errors++;
            $display("FAIL wrap_first_31: got v=%b idx=%0d oh=%h, expected v=1 idx=31 oh=80000000",
                     grant_valid, grant_idx, grant_onehot);
        end
        checks++;
        if (dbg_ptr_o !== 5'd0) begin
            errors++;
            $display("FAIL wrap_ptr_zero: got %0d expected 0", dbg_ptr_o);
        end
        req = 32'h0000_0001;
        tick();
        checks++;
        if (grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_bubble: got v=%b expected 0", grant_valid);
        end
        tick();
        checks++;
        if ({grant_valid, grant_idx, grant_onehot} !== {1'b1, 5'd0, 32'h0000_0001}) begin
            errors++;
            $display("FAIL wrap_then_0: got v=%b idx=%0d oh=%h, expected v=1 idx=0 oh=00000001",
                     grant_valid, grant_idx, grant_onehot);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_enable();
        En  = 1'b0;
        req = 32'h0000_0004;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if ({grant_valid, grant_idx, grant_onehot} !== {1'b0, 5'd0, 32'h0}) begin
                errors++;
                $display("FAIL enable_off cyc%0d: got v=%b idx=%0d oh=%h, expected all zero",
                         c, grant_valid, grant_idx, grant_onehot);
            end
        end
        En = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({grant_valid, grant_idx, grant_onehot} !== {1'b1, 5'd2, 32'h0000_0004}) begin
                errors++;
                $display("FAIL enable_grant cyc%0d: got v=%b idx=%0d oh=%h, expected v=1 idx=2 oh=00000004",
                         c, grant_valid, grant_idx, grant_onehot);
            end
        end
        En = 1'b0;
        tick();
        checks++;
        if ({grant_valid, grant_idx, grant_onehot} !== {1'b0, 5'd0, 32'h0}) begin
            errors++;
            $display("FAIL enable_drop: got v=%b idx=%0d oh=%h, expected all zero",
                     grant_valid, grant_idx, grant_onehot);
        end
        req = '0;
        En  = 1'b1;
        tick();
    endtask

    task automatic test_hold();
        // the pointer is at 3 after the grant to 2
        req = 32'h0000_0028;
`ifdef ARB_TIMEOUT_EN
        begin
            logic [IDXW-1:0] exp_seq [11];
            exp_seq = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd0, 5'd5, 5'd5, 5'd5, 5'd5, 5'd0, 5'd3};
            for (int c = 0; c < 11; c++) begin
                tick();
                checks++;
                if (c == 4 || c == 9) begin
                    if (grant_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL timeout_bubble cyc%0d: got v=%b expected 0", c, grant_valid);
                    end
                end else begin
                    if ({grant_valid, grant_idx} !== {1'b1, exp_seq[c]}) begin
                        errors++;
                        $display("FAIL timeout_seq cyc%0d: got v=%b idx=%0d, expected v=1 idx=%0d",
                                 c, grant_valid, grant_idx, exp_seq[c]);
                    end
                end
            end
        end
`else
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if ({grant_valid, grant_idx, grant_onehot} !== {1'b1, 5'd3, 32'h0000_0008}) begin
                errors++;
                $display("FAIL hold_forever cyc%0d: got v=%b idx=%0d oh=%h, expected v=1 idx=3 oh=00000008",
                         c, grant_valid, grant_idx, grant_onehot);
            end
        end
`endif
        req = '0;
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        En     = 1'b0;
        req    = '0;
        tick();
        test_reset();
        test_sweep();
        test_rotation();
        test_wrap();
        test_enable();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
